// File: rtl/imm_ext_stage.sv
// imm_ext_stage: immediate extension pipeline stage with a one-entry skid buffer.
//
// Extends an IN_W-bit immediate to OUT_W bits according to in_mode:
//   00 zero-extend, 01 sign-extend, 10 high placement (low bits zero), 11 reserved.
// Reserved modes produce out_imm = 0 with out_err = 1.
//
// Optional feature macro: IMM_EXT_HIGH_EN
//   defined   -> mode 10 places the immediate in the upper bits.
//   undefined -> mode 10 is treated as reserved, exactly like mode 11.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   flush      synchronous discard of both held entries
//   in_valid   upstream offers an immediate
//   in_ready   stage can accept (depends only on registered skid state)
//   in_mode    extension mode
//   in_imm     raw immediate
//   out_valid  out_imm/out_err hold a result
//   out_ready  downstream consumes when out_valid is also high
//   out_imm    extended immediate
//   out_err    result came from an illegal mode

module imm_ext_stage #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_err
);

`ifdef IMM_EXT_HIGH_EN
    localparam int unsigned PadW = OUT_W - IN_W;
`endif

    // Extension of the incoming immediate
    logic [OUT_W-1:0] ext_imm;
    logic             ext_err;

    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (in_mode)
            2'b00: ext_imm = OUT_W'(in_imm);
            2'b01: ext_imm = OUT_W'($signed(in_imm));
`ifdef IMM_EXT_HIGH_EN
            2'b10: ext_imm = OUT_W'(in_imm) << PadW;
`endif
            default: begin
                ext_imm = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    // Output register and skid entry
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_imm_q, out_imm_d;
    logic             out_err_q, out_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
    logic             skid_err_q, skid_err_d;

    logic accept;
    logic drain;
    logic out_free;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;
    assign out_free = ~out_valid_q | drain;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // Skid holds the older entry; accept is impossible while it is valid
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = ext_imm;
                out_err_d   = ext_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_err_d   = ext_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage (16->32 instance plus an 8->8 instance).
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_err;

    logic        e_flush;
    logic        e_in_valid;
    logic        e_in_ready;
    logic [1:0]  e_in_mode;
    logic [7:0]  e_in_imm;
    logic        e_out_valid;
    logic        e_out_ready;
    logic [7:0]  e_out_imm;
    logic        e_out_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb[$];
    logic        stall_pend = 1'b0;
    logic [31:0] held_imm;
    logic        held_err;

    always #5 clk = ~clk;

    imm_ext_stage #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err)
    );

    imm_ext_stage #(.IN_W(8), .OUT_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .flush     (e_flush),
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .in_mode   (e_in_mode),
        .in_imm    (e_in_imm),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready),
        .out_imm   (e_out_imm),
        .out_err   (e_out_err)
    );

    // Reference model: {err, imm32}
    function automatic logic [32:0] exp_of(input logic [1:0] m, input logic [15:0] v);
        case (m)
            2'b00: return {1'b0, 16'h0000, v};
            2'b01: return {1'b0, {16{v[15]}}, v};
`ifdef IMM_EXT_HIGH_EN
            2'b10: return {1'b0, v, 16'h0000};
`endif
            default: return {1'b1, 32'h0000_0000};
        endcase
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst || flush) begin
            sb.delete();
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_imm !== held_imm || out_err !== held_err) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b imm=%h err=%b, want v=1 imm=%h err=%b",
                             out_valid, out_imm, out_err, held_imm, held_err);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got imm=%h err=%b, want no output",
                             out_imm, out_err);
                end else begin
                    e = sb.pop_front();
                    if (out_imm !== e[31:0] || out_err !== e[32]) begin
                        n_fail++;
                        $display("FAIL sb_data: got imm=%h err=%b, want imm=%h err=%b",
                                 out_imm, out_err, e[31:0], e[32]);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_of(in_mode, in_imm));
            stall_pend = out_valid && !out_ready;
            held_imm   = out_imm;
            held_err   = out_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'hFFFF;
        out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b rdy=%b imm=%h err=%b, want v=0 rdy=1 imm=0 err=0",
                     out_valid, in_ready, out_imm, out_err);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_modes();
        logic [1:0]  modes[4] = '{2'b01, 2'b00, 2'b10, 2'b11};
        logic [31:0] want_imm;
        logic        want_err;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin want_imm = 32'hFFFF_8001; want_err = 1'b0; end
                1: begin want_imm = 32'h0000_8001; want_err = 1'b0; end
`ifdef IMM_EXT_HIGH_EN
                2: begin want_imm = 32'h8001_0000; want_err = 1'b0; end
`else
                2: begin want_imm = 32'h0000_0000; want_err = 1'b1; end
`endif
                default: begin want_imm = 32'h0000_0000; want_err = 1'b1; end
            endcase
            in_valid = 1'b1; in_mode = modes[i]; in_imm = 16'h8001;
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_imm !== want_imm || out_err !== want_err) begin
                n_fail++;
                $display("FAIL mode_%b: got v=%b imm=%h err=%b, want v=1 imm=%h err=%b",
                         modes[i], out_valid, out_imm, out_err, want_imm, want_err);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_mode = 2'b00;
        in_valid = 1'b1; in_imm = 16'h0001;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== 32'h1) begin
            n_fail++;
            $display("FAIL b2b_first: got rdy=%b v=%b imm=%h, want rdy=1 v=1 imm=1",
                     in_ready, out_valid, out_imm);
        end
        in_imm = 16'h0002;
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got in_ready=%b, want 0", in_ready);
        end
        in_imm = 16'h0003;
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_imm !== 32'h1) begin
            n_fail++;
            $display("FAIL b2b_hold: got rdy=%b imm=%h, want rdy=0 imm=1", in_ready, out_imm);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_imm !== 32'h2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got imm=%h rdy=%b, want imm=2 rdy=1", out_imm, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'h3) begin
            n_fail++;
            $display("FAIL b2b_third: got v=%b imm=%h, want v=1 imm=3", out_valid, out_imm);
        end
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drained: got v=%b pending=%0d, want v=0 pending=0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_throughput();
        int stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_mode = 2'($urandom_range(0, 3)); in_imm = 16'($urandom);
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL throughput: got %0d not-ready cycles, want 0", stalls);
        end
        tick(); tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_mode = 2'b00;
        in_valid = 1'b1; in_imm = 16'h0011; tick();
        in_imm = 16'h0022; tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: got rdy=%b v=%b, want rdy=0 v=1", in_ready, out_valid);
        end
        flush = 1'b1; in_imm = 16'h0033; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nothing: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_rst_stall();
        out_ready = 1'b0; in_mode = 2'b01;
        in_valid = 1'b1; in_imm = 16'h1234; tick();
        in_imm = 16'h5678; tick();
        in_valid = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stall: got v=%b imm=%h err=%b rdy=%b, want v=0 imm=0 err=0 rdy=1",
                     out_valid, out_imm, out_err, in_ready);
        end
        out_ready = 1'b1; tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall_empty: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_mode   = 2'($urandom_range(0, 3));
            in_imm    = 16'($urandom);
            tick();
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got v=%b pending=%0d, want v=0 pending=0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_equal_width();
        logic [1:0] modes[3] = '{2'b01, 2'b00, 2'b11};
        logic [7:0] imms[3]  = '{8'h80, 8'h7F, 8'hAA};
        logic [8:0] wants[3] = '{{1'b0, 8'h80}, {1'b0, 8'h7F}, {1'b1, 8'h00}};
        e_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e_in_valid = 1'b1; e_in_mode = modes[i]; e_in_imm = imms[i];
            tick();
            e_in_valid = 1'b0;
            n_checks++;
            if (e_out_valid !== 1'b1 || e_out_imm !== wants[i][7:0] || e_out_err !== wants[i][8])
            begin
                n_fail++;
                $display("FAIL eqw_mode_%b: got v=%b imm=%h err=%b, want v=1 imm=%h err=%b",
                         modes[i], e_out_valid, e_out_imm, e_out_err, wants[i][7:0], wants[i][8]);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_imm = '0;
        out_ready = 1'b0;
        e_flush = 1'b0; e_in_valid = 1'b0; e_in_mode = 2'b00; e_in_imm = '0;
        e_out_ready = 1'b1;
        test_reset();
        test_modes();
        test_back_to_back();
        test_throughput();
        test_flush();
        test_rst_stall();
        test_random();
        test_equal_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
